// File: rtl/mux_scan_pkg.sv
// Shared widths and state encoding for the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int CH_W       = 2;
    localparam int SETTLE_W   = 4;
    localparam int SETTLE_MAX = 15;
    localparam int FRAME_W    = 1 << CH_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side signals of the scan controller.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic               start;
    logic               cont;
    logic               y;
    logic               ready;
    logic               e;
    logic               s1;
    logic               s0;
    logic [FRAME_W-1:0] data;
    logic               valid;
    logic               busy;

    modport master (
        output start, cont, y, ready,
        input  e, s1, s0, data, valid, busy
    );

    modport slave (
        input  start, cont, y, ready,
        output e, s1, s0, data, valid, busy
    );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle down-counter; done marks the last settle cycle (count == 1).
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four inputs of a 4:1 mux into a frame and hands it off with VALID/READY.
//   state  | meaning
//   IDLE   | mux disabled, waiting for START
//   SETTLE | mux enabled on current channel, waiting SETTLE_CYCLES
//   SAMPLE | one cycle; Y captured into frame[channel] at its closing edge
//   DONE   | frame presented on DATA with VALID until handshake
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    mux_scan_ctrl_if.slave bus
);

    localparam logic [1:0]          IDLE      = ST_IDLE;
    localparam logic [1:0]          SETTLE    = ST_SETTLE;
    localparam logic [1:0]          SAMPLE    = ST_SAMPLE;
    localparam logic [1:0]          DONE      = ST_DONE;
    localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(FRAME_W - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

    logic [1:0]         state, state_nxt;
    logic [CH_W-1:0]    ch, ch_nxt;
    logic [FRAME_W-1:0] frame, frame_cap;
    logic [FRAME_W-1:0] data_q;
    logic               tmr_load, tmr_dec, tmr_done;
    logic               active_nxt;
    logic               e_q, s1_q, s0_q, valid_q, busy_q;

    settle_timer #(.W(SETTLE_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        frame_cap = frame;
        frame_cap[ch] = bus.y;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SETTLE;
                    ch_nxt    = '0;
                    tmr_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_done) state_nxt = SAMPLE;
                else          tmr_dec   = 1'b1;
            end
            SAMPLE: begin
                if (ch == CH_LAST) begin
                    state_nxt = DONE;
                    ch_nxt    = '0;
                end else begin
                    state_nxt = SETTLE;
                    ch_nxt    = ch + CH_W'(1);
                    tmr_load  = 1'b1;
                end
            end
            DONE: begin
                // START is ignored here; CONT alone picks the follow-up.
                if (bus.ready) begin
                    ch_nxt = '0;
                    if (bus.cont) begin
                        state_nxt = SETTLE;
                        tmr_load  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        active_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ch      <= '0;
            frame   <= '0;
            data_q  <= '0;
            e_q     <= 1'b1;
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            if (state == SAMPLE) begin
                frame <= frame_cap;
                if (state_nxt == DONE) data_q <= frame_cap;
            end
            e_q     <= ~active_nxt;
            s1_q    <= active_nxt & ch_nxt[1];
            s0_q    <= active_nxt & ch_nxt[0];
            valid_q <= (state_nxt == DONE);
            busy_q  <= active_nxt;
        end
    end

    assign bus.e     = e_q;
    assign bus.s1    = s1_q;
    assign bus.s0    = s0_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed-plus-random bench for mux_scan_ctrl at SETTLE_CYCLES = 2, 1 and 15.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v, cont_v, ready_v;
    logic [2:0] e_v, s1_v, s0_v, valid_v, busy_v, y_v;
    logic [3:0] data_v [3];
    logic [3:0] mux_in [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux_scan_ctrl_if bus ();
        assign bus.start  = start_v[g];
        assign bus.cont   = cont_v[g];
        assign bus.ready  = ready_v[g];
        assign bus.y      = y_v[g];
        assign e_v[g]     = bus.e;
        assign s1_v[g]    = bus.s1;
        assign s0_v[g]    = bus.s0;
        assign valid_v[g] = bus.valid;
        assign busy_v[g]  = bus.busy;
        assign data_v[g]  = bus.data;
        // Behavioural 4:1 mux with active-high disable.
        assign y_v[g] = bus.e ? 1'b0 : mux_in[g][{bus.s1, bus.s0}];
        mux_scan_ctrl #(.SETTLE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int sc(int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the START edge; returns at the first VALID negedge.
    task automatic wait_valid(int d, output int k, output int elow, output int seqerr);
        k = 0; elow = 0; seqerr = 0;
        while (!valid_v[d] && k < 400) begin
            if (!e_v[d]) begin
                if ({s1_v[d], s0_v[d]} != 2'(elow / (sc(d) + 1))) seqerr++;
                elow++;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_idle(int d, logic [3:0] exp_data, string tag);
        chk({tag, "_e"},     32'(e_v[d]), 1);
        chk({tag, "_sel"},   32'({s1_v[d], s0_v[d]}), 0);
        chk({tag, "_data"},  32'(data_v[d]), 32'(exp_data));
        chk({tag, "_valid"}, 32'(valid_v[d]), 0);
        chk({tag, "_busy"},  32'(busy_v[d]), 0);
    endtask

    // Runs one scan from IDLE and stops in DONE (no handshake).
    task automatic scan(int d, logic [3:0] pat, string tag);
        int k, el, se;
        mux_in[d]  = pat;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        wait_valid(d, k, el, se);
        chk({tag, "_lat"},  32'(k),  32'(4 * (sc(d) + 1)));
        chk({tag, "_elow"}, 32'(el), 32'(4 * (sc(d) + 1)));
        chk({tag, "_seq"},  32'(se), 0);
        chk({tag, "_data"}, 32'(data_v[d]), 32'(pat));
        chk({tag, "_done_e"}, 32'(e_v[d]), 1);
        chk({tag, "_done_busy"}, 32'(busy_v[d]), 0);
    endtask

    task automatic handshake(int d, string tag);
        ready_v[d] = 1'b1;
        @(negedge clk);
        ready_v[d] = 1'b0;
        chk({tag, "_hs_valid"}, 32'(valid_v[d]), 0);
        chk({tag, "_hs_busy"},  32'(busy_v[d]), 0);
    endtask

    initial begin
        int k, el, se, cnt;
        logic [3:0] pats [3];
        logic [3:0] p;

        rst = 1'b1; start_v = '0; cont_v = '0; ready_v = '0;
        for (int i = 0; i < 3; i++) mux_in[i] = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) check_idle(i, 4'h0, "reset");

        // I0..I3 = 1,0,1,1, then READY held low with toggling inputs.
        scan(0, 4'b1101, "basic");
        for (int i = 0; i < 10; i++) begin
            mux_in[0] = 4'($urandom);
            @(negedge clk);
            chk("hold_data",  32'(data_v[0]), 32'hD);
            chk("hold_valid", 32'(valid_v[0]), 1);
            chk("hold_e",     32'(e_v[0]), 1);
        end
        handshake(0, "basic");

        for (int r = 0; r < 4; r++) begin
            p = 4'($urandom);
            scan(0, p, "rand");
            handshake(0, "rand");
        end

        // Back-to-back frames with READY tied high.
        for (int f = 0; f < 3; f++) pats[f] = 4'($urandom);
        cont_v[0] = 1'b1; ready_v[0] = 1'b1;
        mux_in[0] = pats[0];
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_valid(0, k, el, se);
            chk("b2b_lat",  32'(k), 12);
            chk("b2b_seq",  32'(se), 0);
            chk("b2b_data", 32'(data_v[0]), 32'(pats[f]));
            if (f < 2) mux_in[0] = pats[f + 1];
            else       cont_v[0] = 1'b0;
            @(negedge clk);
            chk("b2b_valid_drop", 32'(valid_v[0]), 0);
            chk("b2b_busy", 32'(busy_v[0]), (f < 2) ? 1 : 0);
        end
        ready_v[0] = 1'b0;

        // Reset during SETTLE of channel 2.
        mux_in[0] = 4'hF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        k = 0;
        while (!(e_v[0] == 1'b0 && {s1_v[0], s0_v[0]} == 2'b10) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_reach_ch2", 32'(k < 100), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, 4'h0, "rst_mid");
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid_v[0] || busy_v[0]) cnt++;
        end
        chk("rst_mid_no_valid", 32'(cnt), 0);

        // START held through the scan and DONE; coincident with handshake at CONT=0.
        p = 4'($urandom);
        mux_in[0] = p;
        start_v[0] = 1'b1;
        @(negedge clk);
        wait_valid(0, k, el, se);
        chk("ign_lat",  32'(k), 12);
        chk("ign_elow", 32'(el), 12);
        chk("ign_data", 32'(data_v[0]), 32'(p));
        repeat (3) @(negedge clk);
        chk("ign_done_valid", 32'(valid_v[0]), 1);
        chk("ign_done_busy",  32'(busy_v[0]), 0);
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        ready_v[0] = 1'b0;
        chk("ign_hs_valid", 32'(valid_v[0]), 0);
        chk("ign_hs_busy",  32'(busy_v[0]), 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_v[0] || busy_v[0]) cnt++;
        end
        chk("ign_no_second_frame", 32'(cnt), 0);

        // Shortest and longest settle times.
        for (int d = 1; d < 3; d++) begin
            for (int r = 0; r < 2; r++) begin
                p = 4'($urandom);
                scan(d, p, (d == 1) ? "settle1" : "settle15");
                handshake(d, (d == 1) ? "settle1" : "settle15");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
